// File: rtl/morse_tx_param.sv
// morse_tx_param: plays an MSB-first on/off unit pattern at DIV clocks per unit, then a forced-low gap.
// Optional feature macro: MORSE_TX_REPEAT_EN (adds repeat_en input for back-to-back replay).
module morse_tx_param #(
  parameter int DIV       = 4,
  parameter int PAT_W     = 16,
  parameter int GAP_UNITS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       start,
  input  logic [PAT_W-1:0]           pat_in,
  input  logic [$clog2(PAT_W+1)-1:0] len_in,
`ifdef MORSE_TX_REPEAT_EN
  // "repeat" is a reserved word, hence the suffix.
  input  logic                       repeat_en,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       led_out
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_UNITS > 0) ? GAP_UNITS - 1 : 0);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             led_q, led_d;
  logic             done_q, done_d;
  logic             active, tick, pass_end, replay;
  logic [PAT_W-1:0] reload_pat;
  logic [LEN_W-1:0] reload_len, len_clamped;

  assign active      = (state_q != S_IDLE);
  assign tick        = active && enable && (cnt_q == '0);
  assign len_clamped = (len_in > LEN_MAX) ? LEN_MAX : len_in;

`ifdef MORSE_TX_REPEAT_EN
  // Replay source is kept apart from the shift register, which is consumed as units go out.
  logic [PAT_W-1:0] pat_lat_q, pat_lat_d;
  logic [LEN_W-1:0] len_lat_q, len_lat_d;

  always_comb begin
    pat_lat_d = pat_lat_q;
    len_lat_d = len_lat_q;
    if (state_q == S_IDLE && start) begin
      pat_lat_d = pat_in;
      len_lat_d = len_clamped;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_lat_q <= '0;
      len_lat_q <= '0;
    end else begin
      pat_lat_q <= pat_lat_d;
      len_lat_q <= len_lat_d;
    end
  end

  assign replay     = repeat_en;
  assign reload_pat = pat_lat_q;
  assign reload_len = len_lat_q;
`else
  assign replay     = 1'b0;
  assign reload_pat = '0;
  assign reload_len = '0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    led_d    = led_q;
    done_d   = 1'b0;
    pass_end = 1'b0;

    if (active && enable) cnt_d = tick ? DIV_LOAD : cnt_q - CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_in == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_SEND;
            shift_d = pat_in;
            len_d   = len_clamped;
            cnt_d   = DIV_LOAD;
            led_d   = pat_in[PAT_W-1];
          end
        end
      end
      S_SEND: begin
        if (tick) begin
          if (len_q == LEN_W'(1)) begin
            if (GAP_UNITS == 0) begin
              pass_end = 1'b1;
            end else begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
              led_d   = 1'b0;
            end
          end else begin
            shift_d = shift_q << 1;
            len_d   = len_q - LEN_W'(1);
            led_d   = shift_q[PAT_W-2];
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == '0) pass_end = 1'b1;
          else             gap_d    = gap_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pass_end) begin
      if (replay) begin
        state_d = S_SEND;
        shift_d = reload_pat;
        len_d   = reload_len;
        led_d   = reload_pat[PAT_W-1];
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        led_d   = 1'b0;
      end
    end
  end

  // NOTE: non-blocking assignments, so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign busy    = active;
  assign done    = done_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_morse_tx_param.sv
// tb_morse_tx_param: directed scenarios plus randomized traffic against a unit-arithmetic reference model.
// Build with MORSE_TX_REPEAT_EN defined to also exercise the repeat input.
module tb_morse_tx_param;

  localparam int DIV   = 4;
  localparam int PAT_W = 16;
  localparam int GAP   = 3;
  localparam int LEN_W = $clog2(PAT_W + 1);
`ifdef MORSE_TX_REPEAT_EN
  localparam bit REPEAT_BUILD = 1'b1;
`else
  localparam bit REPEAT_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, enable, start, rep;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] len_in;
  logic             busy, done, led_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cyc = -1;
  int busy_cnt = 0;

  // Reference model: a transfer is (len + GAP) units of DIV enabled cycles each.
  bit               m_active = 1'b0;
  bit               m_done   = 1'b0;
  int               m_e      = 0;
  int               m_len    = 0;
  logic [PAT_W-1:0] m_pat    = '0;

  always #5 clk = ~clk;

  morse_tx_param #(.DIV(DIV), .PAT_W(PAT_W), .GAP_UNITS(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .pat_in    (pat_in),
    .len_in    (len_in),
`ifdef MORSE_TX_REPEAT_EN
    .repeat_en (rep),
`endif
    .busy      (busy),
    .done      (done),
    .led_out   (led_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  function automatic int exp_led();
    int u;
    if (!m_active) return 0;
    u = m_e / DIV;
    if (u < m_len) return int'(m_pat[PAT_W-1-u]);
    return 0;
  endfunction

  task automatic model_clear();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_e      = 0;
  endtask

  task automatic model_edge();
    int l;
    bit r;
    r = rep && REPEAT_BUILD;
    if (reset) begin
      model_clear();
      return;
    end
    m_done = 1'b0;
    if (!m_active) begin
      if (start) begin
        l = (int'(len_in) > PAT_W) ? PAT_W : int'(len_in);
        if (l == 0) begin
          m_done = 1'b1;
        end else begin
          m_active = 1'b1;
          m_e      = 0;
          m_len    = l;
          m_pat    = pat_in;
        end
      end
    end else if (enable) begin
      m_e++;
      if (m_e == (m_len + GAP) * DIV) begin
        if (r) begin
          m_e = 0;
        end else begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("busy", busy, m_active);
    check("done", done, m_done);
    check("led_out", led_out, exp_led());
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge, inputs then changeable.
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    compare_all();
    if (done) done_cyc = cyc;
    if (busy) busy_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic go(input logic [PAT_W-1:0] p, input int l);
    pat_in   = p;
    len_in   = LEN_W'(l);
    start    = 1'b1;
    cyc      = 0;
    done_cyc = -1;
    busy_cnt = 0;
    step();
    start    = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    start  = 1'b0;
    rep    = 1'b0;
    pat_in = '0;
    len_in = '0;
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b0;
    step();

    // Letter A, 10111, plain timing.
    go(16'hB800, 5);
    run_to(36);
    check("t1_done_cycle", done_cyc, 33);
    check("t1_busy_cycles", busy_cnt, 32);

    // Zero length: immediate done, never busy.
    go(16'h1234, 0);
    run_to(4);
    check("t2_done_cycle", done_cyc, 1);
    check("t2_busy_cycles", busy_cnt, 0);

    // Enable low for cycles 10..16 shifts the timeline by 7.
    go(16'hB800, 5);
    run_to(10);
    enable = 1'b0;
    run_to(17);
    check("t3_led_hold", led_out, 1);
    enable = 1'b1;
    run_to(43);
    check("t3_done_cycle", done_cyc, 40);
    check("t3_busy_cycles", busy_cnt, 39);

    // Start while busy ignored; start in the done cycle accepted.
    go(16'hB800, 5);
    run_to(15);
    start  = 1'b1;
    pat_in = 16'hFFFF;
    len_in = LEN_W'(16);
    step();
    start  = 1'b0;
    run_to(33);
    check("t4_done_cycle", done_cyc, 33);
    pat_in = 16'h8000;
    len_in = LEN_W'(1);
    start  = 1'b1;
    step();
    start  = 1'b0;
    check("t4_new_msb", led_out, 1);
    run_to(54);
    check("t4_second_done", done_cyc, 50);

    // Asynchronous reset mid-transfer, then a clean rerun.
    go(16'hB800, 5);
    run_to(11);
    @(posedge clk);
    model_edge();
    cyc++;
    #2 reset = 1'b1;
    model_clear();
    #1;
    check("t5_led_async", led_out, 0);
    check("t5_busy_async", busy, 0);
    @(negedge clk);
    compare_all();
    done_cyc = -1;
    step();
    step();
    reset = 1'b0;
    repeat (40) step();
    check("t5_no_done", done_cyc, -1);
    go(16'hB800, 5);
    run_to(36);
    check("t5_rerun_done", done_cyc, 33);
    check("t5_rerun_busy", busy_cnt, 32);

    // Repeat for the first pass only.
    rep = 1'b1;
    go(16'hB800, 5);
    run_to(33);
    rep = 1'b0;
`ifdef MORSE_TX_REPEAT_EN
    check("t6_no_mid_done", done, 0);
    check("t6_second_pass_led", led_out, 1);
    run_to(68);
    check("t6_done_cycle", done_cyc, 65);
    check("t6_busy_cycles", busy_cnt, 64);
`else
    run_to(36);
    check("t6_done_cycle", done_cyc, 33);
    check("t6_busy_cycles", busy_cnt, 32);
`endif

    // Randomized traffic: clamped lengths, stalls, stray starts, repeats, rare resets.
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(9, 0) != 0);
      start  = ($urandom_range(7, 0) == 0);
      pat_in = PAT_W'($urandom);
      len_in = LEN_W'($urandom_range(31, 0));
      rep    = ($urandom_range(3, 0) == 0);
      reset  = ($urandom_range(499, 0) == 0);
      step();
    end
    reset = 1'b0;
    start = 1'b0;
    rep   = 1'b0;
    enable = 1'b1;
    repeat (150) step();
    check("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
